// File: rtl/seq_divider.sv
// Radix-2 restoring divider: one quotient bit per cycle, quotient to ZLo, remainder to ZHi.
// Define DIV_SIGNED_EN for two's-complement signed division (default: unsigned).
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] p, q, d_mag, a_raw;
    logic [CW-1:0]    count;
    logic             neg_q, neg_r, dz;

    logic             accept, last_iter, ge;
    logic [WIDTH-1:0] a_mag, b_mag, p_next, q_fix, r_fix;
    logic             a_neg, b_neg;
    logic [WIDTH:0]   shifted;

`ifdef DIV_SIGNED_EN
    assign a_neg = dividend[WIDTH-1];
    assign b_neg = divisor[WIDTH-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;
`else
    assign a_neg = 1'b0;
    assign b_neg = 1'b0;
    assign a_mag = dividend;
    assign b_mag = divisor;
`endif

    assign accept    = start && (state == IDLE || state == DONE);
    assign last_iter = (count == CW'(WIDTH - 1));

    // P is always below the divisor, so the shifted value needs one extra bit
    assign shifted = {p, q[WIDTH-1]};
    assign ge      = (shifted >= {1'b0, d_mag});
    assign p_next  = ge ? WIDTH'(shifted - {1'b0, d_mag})
                        : shifted[WIDTH-1:0];

    assign q_fix = neg_q ? -q : q;
    assign r_fix = neg_r ? -p : p;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clock) begin
        if (clear) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) next_state = (divisor == '0) ? FIX : RUN;
            end
            RUN: begin
                if (last_iter) next_state = FIX;
            end
            FIX: begin
                next_state = DONE;
            end
            DONE: begin
                if (accept) next_state = (divisor == '0) ? FIX : RUN;
                else        next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            p           <= '0;
            q           <= '0;
            d_mag       <= '0;
            a_raw       <= '0;
            count       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            a_raw <= dividend;
            p     <= '0;
            q     <= a_mag;
            d_mag <= b_mag;
            count <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            dz    <= (divisor == '0);
        end else if (state == RUN) begin
            count <= count + CW'(1);
            p     <= p_next;
            q     <= {q[WIDTH-2:0], ge};
        end else if (state == FIX) begin
            // Remainder takes the dividend's sign: truncating division
            quotient    <= dz ? '1 : q_fix;
            remainder   <= dz ? a_raw : r_fix;
            div_by_zero <= dz;
        end
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle radix-2 restoring divider that computes DIV for the datapath. The ALU's combinational divide path is too slow at the target clock, so this block produces the quotient and remainder instead. The results feed the 64-bit Z result path: remainder goes to ZHi and quotient goes to ZLo. The control unit drives `start`, stalls on `busy`, and latches Z when `done` pulses.

## Interface
- `WIDTH`, default 32: operand width in bits; quotient and remainder are also `WIDTH` bits.
- `clock`  in  1  single rising-edge clock.
- `clear`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `dividend`  in  WIDTH  A operand; sampled on the edge that accepts `start`.
- `divisor`  in  WIDTH  B operand; sampled with `dividend`.
- `busy`  out  1  high from the cycle after accept until `done` inclusive.
- `done`  out  1  one-cycle pulse; results are valid in this cycle.
- `quotient`  out  WIDTH  result to ZLo; held until the next accepted `start`.
- `remainder`  out  WIDTH  result to ZHi; held until the next accepted `start`.
- `div_by_zero`  out  1  set with `done` when `divisor` == 0; held like the results.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE + `start`: latch operands, take magnitudes (signed mode), zero the partial remainder, set iteration count to 0.
  - If `divisor` == 0, go to FIX.
  - Otherwise go to RUN.
- RUN, one bit per cycle, MSB first:
  - Shift {P, Q} left by 1.
  - Trial-subtract the divisor magnitude from P using `WIDTH`+1 bits.
  - If the result is non-negative, keep it and set Q[0]=1; otherwise restore P and set Q[0]=0.
  - After exactly `WIDTH` iterations, go to FIX.
- FIX:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend; this truncates toward zero, matching Verilog `/` and `%`.
  - Outputs register at the FIX→DONE edge.
  - Go to DONE.
- DONE: assert `done` for one cycle, then go to IDLE. A `start` seen in DONE is accepted as if in IDLE (back-to-back operation).
- Divide by zero: `quotient` = all ones, `remainder` = `dividend` unchanged, `div_by_zero` = 1.
- Overflow, `dividend` = 0x80000000 and `divisor` = 0xFFFFFFFF (−1): `quotient` = 0x80000000, `remainder` = 0, no flag. This falls out of unsigned magnitude arithmetic.
- `start` in RUN or FIX is ignored; there is no queueing.
- `clear` in any state, including mid-RUN:
  - Next state is IDLE.
  - `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, count=0.
  - `clear` overrides a simultaneous `start`.

## Timing
- Reset values of all outputs: 0.
- `start` accepted at edge k: `busy` is high from cycle k+1.
- Normal operation:
  - RUN occupies edges k+1 … k+`WIDTH`.
  - FIX is at edge k+`WIDTH`+1.
  - `done` is high in the cycle after edge k+`WIDTH`+1; the consumer samples it at edge k+`WIDTH`+2.
  - For `WIDTH`=32, `done` is sampled at k+34.
- Divide by zero: FIX at k+1; `done` is sampled at edge k+2.
- Outputs change only at the FIX→DONE edge or on `clear`; they are stable in every other cycle.
- Minimum start-to-start spacing: `WIDTH`+2 cycles.

## Configuration
- `DIV_SIGNED_EN` defined: two's-complement signed division as described above, with magnitude conversion and sign fix in FIX.
- `DIV_SIGNED_EN` undefined:
  - Operands are unsigned and FIX only registers the outputs.
  - Overflow case: 0x80000000 / 0xFFFFFFFF gives `quotient` = 0, `remainder` = 0x80000000.
  - Divide-by-zero behaviour and all latencies are unchanged.

## Test plan
- `dividend`=100, `divisor`=7, `start` at edge k → `done` sampled at k+34, `quotient`=14, `remainder`=2, `busy` high k+1…k+34.
- Signed (`DIV_SIGNED_EN`): −100 / 7 → `quotient`=0xFFFFFFF2, `remainder`=0xFFFFFFFE; 100 / −7 → `quotient`=0xFFFFFFF2, `remainder`=2.
- 0x80000000 / 0xFFFFFFFF → `quotient`=0x80000000, `remainder`=0, `div_by_zero`=0; unsigned build → `quotient`=0, `remainder`=0x80000000.
- 0x1234 / 0 → `done` sampled at k+2, `div_by_zero`=1, `quotient`=0xFFFFFFFF, `remainder`=0x1234.
- `start` at k, second `start` with new operands at k+5 → ignored, first result only; new `start` in the DONE cycle → accepted, second `done` sampled 34 cycles later.
- `clear` asserted at k+10 mid-RUN → next cycle `busy`=0, all outputs 0, no `done` pulse ever appears for that operation.
